// File: rtl/mem_client_rmw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_client_rmw: arbiter client doing read, read-add-write or write on one  |
// | fixed word. Optional macro MEMCLIENT_TIMEOUT_EN adds a grant-wait timeout.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_client_rmw #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDRESS    = 8'h18,
  parameter int                    PERIOD     = 27000000,
  parameter int                    MODE       = 1,
  parameter logic [DATA_WIDTH-1:0] STEP       = {{(DATA_WIDTH-1){1'b0}}, 1'b1},
  parameter bit                    SATURATE   = 1'b0
`ifdef MEMCLIENT_TIMEOUT_EN
  , parameter int                  TIMEOUT    = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] wr_value,
  input  logic                  granted_access,
  output logic                  requesting_memory,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read_write,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic [15:0]           op_count,
  output logic                  timeout
);

  localparam int             CW       = $clog2(PERIOD + 1);
  localparam logic [CW-1:0]  PERIOD_C = CW'(PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_WRITE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic [15:0]           opcnt_q, opcnt_d;
  logic [DATA_WIDTH:0]   sum_w;
  logic [DATA_WIDTH-1:0] incr_w;

`ifdef MEMCLIENT_TIMEOUT_EN
  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;
`endif

  // The extra carry bit tells saturation when the add overflowed.
  assign sum_w  = {1'b0, input_data} + {1'b0, STEP};
  assign incr_w = (SATURATE && sum_w[DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : sum_w[DATA_WIDTH-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (granted_access || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != PERIOD_C) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rw_d     = rw_q;
    dout_d   = dout_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef MEMCLIENT_TIMEOUT_EN
    timeout_d = timeout_q;
    wait_d    = (state_q == S_WAIT) ? wait_q + WW'(1) : '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable && ((cnt_q == PERIOD_C) || trigger)) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          rw_d    = (MODE != 2);
          if (MODE == 2) begin
            dout_d = wr_value;
          end
        end
      end
      S_WAIT: begin
        if (granted_access) begin
          state_d = S_EXEC;
        end
`ifdef MEMCLIENT_TIMEOUT_EN
        // A grant on the limit cycle takes priority over the timeout.
        else if (wait_q == WAIT_LAST) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          rw_d      = 1'b1;
          timeout_d = 1'b1;
        end
`endif
      end
      S_EXEC: begin
        if (MODE == 1) begin
          result_d = input_data;
          dout_d   = incr_w;
          rw_d     = 1'b0;
          state_d  = S_WRITE;
        end else if (MODE == 2) begin
          result_d = dout_q;
          req_d    = 1'b0;
          rw_d     = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          result_d = input_data;
          req_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_WRITE: begin
        req_d   = 1'b0;
        rw_d    = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    opcnt_d = done_d ? opcnt_q + 16'd1 : opcnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      rw_q     <= 1'b1;
      dout_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      opcnt_q  <= '0;
`ifdef MEMCLIENT_TIMEOUT_EN
      wait_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rw_q     <= rw_d;
      dout_q   <= dout_d;
      result_q <= result_d;
      done_q   <= done_d;
      opcnt_q  <= opcnt_d;
`ifdef MEMCLIENT_TIMEOUT_EN
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign requesting_memory = req_q;
  assign address           = ADDRESS;
  assign read_write        = rw_q;
  assign output_data       = dout_q;
  assign result            = result_q;
  assign done              = done_q;
  assign op_count          = opcnt_q;
`ifdef MEMCLIENT_TIMEOUT_EN
  assign timeout           = timeout_q;
`else
  assign timeout           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_client_rmw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_client_rmw: directed bench over several client configurations with  |
// | a completion scoreboard. Revision: 1.0                                     |
// +----------------------------------------------------------------------------+
module tb_mem_client_rmw;

`ifdef MEMCLIENT_TIMEOUT_EN
  localparam int NI = 5;
`else
  localparam int NI = 4;
`endif
  localparam int MODE_OF   [0:4] = '{1, 1, 0, 2, 0};
  localparam int PERIOD_OF [0:4] = '{10, 10, 1000, 10, 1000};
  localparam bit SAT_OF    [0:4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct {
    int          inst;
    logic [31:0] res;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en   [NI];
  logic        trig [NI];
  logic        gnt  [NI];
  logic [31:0] wrv  [NI];
  logic [31:0] din  [NI];
  logic        req  [NI];
  logic [7:0]  addr [NI];
  logic        rw   [NI];
  logic [31:0] dout [NI];
  logic [31:0] res  [NI];
  logic        done [NI];
  logic [15:0] opc  [NI];
  logic        to   [NI];

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_client_rmw #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .ADDRESS(8'h18),
      .PERIOD(PERIOD_OF[g]), .MODE(MODE_OF[g]), .STEP(32'd1), .SATURATE(SAT_OF[g])
`ifdef MEMCLIENT_TIMEOUT_EN
      , .TIMEOUT(8)
`endif
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(en[g]), .trigger(trig[g]),
      .wr_value(wrv[g]), .granted_access(gnt[g]),
      .requesting_memory(req[g]), .address(addr[g]), .read_write(rw[g]),
      .input_data(din[g]), .output_data(dout[g]), .result(res[g]),
      .done(done[g]), .op_count(opc[g]), .timeout(to[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] r, input logic [15:0] c);
    exp_t e;
    e.inst = k; e.res = r; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic wait_req(input int k, input int bound, output int n);
    n = 0;
    while (req[k] !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check("req_arrived", 64'(req[k]), 1);
  endtask

  // Scoreboard side: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (done[k] === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_inst", 64'(k), 64'(e.inst));
          check("sb_result", res[k], e.res);
          check("sb_op_count", opc[k], e.cnt);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      en[k] = 1'b0; trig[k] = 1'b0; gnt[k] = 1'b0; wrv[k] = '0; din[k] = '0;
    end
    en[0] = 1'b1;
    en[1] = 1'b1;
    step(); step();
    check("rst_req", req[0], 0);
    check("rst_addr", addr[0], 8'h18);
    check("rst_rw", rw[0], 1);
    check("rst_dout", dout[0], 0);
    check("rst_result", res[0], 0);
    check("rst_done", done[0], 0);
    check("rst_op_count", opc[0], 0);
    check("rst_timeout", to[0], 0);
    rst_n = 1'b1;

    // RMW: auto request after PERIOD, grant two cycles later
    repeat (10) step();
    check("rmw_no_req_c10", req[0], 0);
    step();
    check("rmw_req_c11", req[0], 1);
    check("rmw_rw_wait", rw[0], 1);
    step();
    check("rmw_req_c12", req[0], 1);
    step();
    gnt[0] = 1'b1; gnt[1] = 1'b1;
    push(0, 32'h5, 16'd1);
    push(1, 32'hFFFF_FFFF, 16'd1);
    step();
    gnt[0] = 1'b0; gnt[1] = 1'b0;
    din[0] = 32'h5; din[1] = 32'hFFFF_FFFF;
    check("rmw_req_exec", req[0], 1);
    check("rmw_rw_exec", rw[0], 1);
    step();
    check("rmw_rw_write", rw[0], 0);
    check("rmw_dout_write", dout[0], 32'h6);
    check("rmw_req_write", req[0], 1);
    check("rmw_result_write", res[0], 32'h5);
    check("sat_dout", dout[1], 32'hFFFF_FFFF);
    step();
    check("rmw_done", done[0], 1);
    check("rmw_req_released", req[0], 0);
    check("rmw_rw_back", rw[0], 1);
    en[1] = 1'b0;

    // Wrap on overflow; next request a full PERIOD after the grant cleared the counter
    wait_req(0, 20, n);
    check("rmw_period_gap", 64'(n), 9);
    gnt[0] = 1'b1;
    push(0, 32'hFFFF_FFFF, 16'd2);
    step();
    gnt[0] = 1'b0;
    din[0] = 32'hFFFF_FFFF;
    step();
    check("wrap_dout", dout[0], 32'h0);
    check("wrap_rw", rw[0], 0);
    check("sat_idle_no_req", req[1], 0);
    step();

    // Asynchronous reset in the middle of the write cycle
    wait_req(0, 20, n);
    gnt[0] = 1'b1;
    step();
    gnt[0] = 1'b0;
    din[0] = 32'h7;
    step();
    check("rst_mid_rw_pre", rw[0], 0);
    check("rst_mid_dout_pre", dout[0], 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", req[0], 0);
    check("rst_mid_rw", rw[0], 1);
    check("rst_mid_dout", dout[0], 0);
    check("rst_mid_result", res[0], 0);
    check("rst_mid_op_count", opc[0], 0);
    step(); step();
    rst_n = 1'b1;
    repeat (10) step();
    check("post_rst_no_req", req[0], 0);
    step();
    check("post_rst_req", req[0], 1);
    check("no_timeout_flag", to[0], 0);

    // Read client on trigger, write client on PERIOD
    rst_n = 1'b0;
    en[0] = 1'b0;
    en[2] = 1'b1; en[3] = 1'b1;
    wrv[3] = 32'h1234;
`ifdef MEMCLIENT_TIMEOUT_EN
    en[4] = 1'b1;
`endif
    step(); step();
    rst_n = 1'b1;
    step();
    step();
    trig[2] = 1'b1;
`ifdef MEMCLIENT_TIMEOUT_EN
    trig[4] = 1'b1;
`endif
    check("rd_no_req_c2", req[2], 0);
    step();
    trig[2] = 1'b0;
`ifdef MEMCLIENT_TIMEOUT_EN
    trig[4] = 1'b0;
    check("to_req_c3", req[4], 1);
`endif
    check("rd_req_c3", req[2], 1);
    check("rd_rw_c3", rw[2], 1);
    step();
    trig[2] = 1'b1;
    step();
    trig[2] = 1'b0;
    gnt[2] = 1'b1;
    push(2, 32'hA5, 16'd1);
    step();
    gnt[2] = 1'b0;
    din[2] = 32'hA5;
    check("rd_req_exec", req[2], 1);
    check("rd_rw_exec", rw[2], 1);
    step();
    check("rd_done", done[2], 1);
    check("rd_req_released", req[2], 0);
    check("rd_rw_no_write", rw[2], 1);
    repeat (3) step();
`ifdef MEMCLIENT_TIMEOUT_EN
    check("to_req_last_wait", req[4], 1);
    check("to_flag_clear", to[4], 0);
`endif
    step();
`ifdef MEMCLIENT_TIMEOUT_EN
    check("to_req_dropped", req[4], 0);
    check("to_flag_set", to[4], 1);
    check("to_op_count", opc[4], 0);
`endif
    check("wr_req_c11", req[3], 1);
    check("wr_rw_c11", rw[3], 0);
    check("wr_dout_c11", dout[3], 32'h1234);
    wrv[3] = 32'h0;
    step();
    check("rd_trigger_dropped", req[2], 0);
    check("wr_dout_held", dout[3], 32'h1234);
    step();
    gnt[3] = 1'b1;
    push(3, 32'h1234, 16'd1);
    step();
    gnt[3] = 1'b0;
    check("wr_rw_exec", rw[3], 0);
    step();
    check("wr_done", done[3], 1);
    check("wr_req_released", req[3], 0);
    check("wr_rw_back", rw[3], 1);
`ifdef MEMCLIENT_TIMEOUT_EN
    trig[4] = 1'b1;
    step();
    trig[4] = 1'b0;
    check("to2_req", req[4], 1);
    gnt[4] = 1'b1;
    push(4, 32'h77, 16'd1);
    step();
    gnt[4] = 1'b0;
    din[4] = 32'h77;
    step();
    check("to2_done", done[4], 1);
    check("to2_flag_sticky", to[4], 1);
`endif
    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
